plugboard: RTL and testbench

- Programmable letter-swap stage (Steckerbrett). One instance feeds the first forward rotor. A second instance consumes the output of the last return rotor.
- Applies up to 13 reciprocal letter pairs to uppercase ASCII characters with a registered 1-cycle valid/done stage. The timing matches the inter-rotor pipeline registers.
- Holds its own pair table, loaded through a checked configuration handshake. A table clear is done by a multi-cycle sweep.

---
 rtl/plugboard.sv | 176 +++++++++++++++++
 tb/tb_plugboard.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard.sv
// Steckerbrett stage: reciprocal letter-swap table with 1-cycle registered data path,
// checked pair-load handshake and 26-cycle clear sweep. Optional macro: PLUGBOARD_LOWERCASE_EN.
module plugboard #(
  parameter int unsigned NUM_LETTERS = 26,
  parameter logic [7:0]  BASE_CHAR   = 8'h41,
  parameter int unsigned MAX_PAIRS   = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_a,
  input  logic [7:0] cfg_b,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic [3:0] pair_count,
  output logic       busy,
  input  logic       valid,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       done
);

  localparam logic [7:0] NL8      = 8'(NUM_LETTERS);
  localparam logic [3:0] MAXP     = 4'(MAX_PAIRS);
  localparam logic [4:0] LAST_IDX = 5'(NUM_LETTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_CLEAR} state_t;

  // Returns {in_range, index}; index is forced to 0 when out of range so table reads stay in bounds.
  function automatic logic [5:0] decode(input logic [7:0] ch);
    logic [7:0] c;
    logic [7:0] diff;
    logic       ok;
    c = ch;
`ifdef PLUGBOARD_LOWERCASE_EN
    if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
`endif
    diff = c - BASE_CHAR;
    ok   = diff < NL8;
    return {ok, ok ? diff[4:0] : 5'd0};
  endfunction

  state_t     state_q, state_d;
  logic [4:0] table_q [NUM_LETTERS];
  logic [4:0] sweep_q, sweep_d;
  logic [4:0] a_q, a_d, b_q, b_d;
  logic       aok_q, aok_d, bok_q, bok_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] dout_q;
  logic       done_q;

  logic [5:0] din_dec, a_dec, b_dec;
  logic       reject, commit_en, sweep_en;

  assign din_dec = decode(din);
  assign a_dec   = decode(cfg_a);
  assign b_dec   = decode(cfg_b);

  assign reject = !aok_q || !bok_q || (a_q == b_q) ||
                  (table_q[a_q] != a_q) || (table_q[b_q] != b_q) || (cnt_q == MAXP);

  assign commit_en = (state_q == S_COMMIT) && !clear;
  assign sweep_en  = (state_q == S_CLEAR) && !clear;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    a_d     = a_q;
    b_d     = b_q;
    aok_d   = aok_q;
    bok_d   = bok_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          a_d     = a_dec[4:0];
          b_d     = b_dec[4:0];
          aok_d   = a_dec[5];
          bok_d   = b_dec[5];
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        sweep_d = sweep_q + 5'd1;
        if (sweep_q == LAST_IDX) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // clear overrides every other transition and discards any pending pair
    if (clear) begin
      state_d = S_CLEAR;
      sweep_d = '0;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aok_q   <= 1'b0;
      bok_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aok_q   <= aok_d;
      bok_q   <= bok_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_LETTERS; i++) table_q[i] <= 5'(i);
    end else if (commit_en) begin
      table_q[a_q] <= b_q;
      table_q[b_q] <= a_q;
    end else if (sweep_en) begin
      table_q[sweep_q] <= sweep_q;
    end
  end

  // During the sweep the table is partially rewritten, so in-range data bypasses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= valid;
      if (valid) begin
        if (din_dec[5]) begin
          if (state_q == S_CLEAR) dout_q <= BASE_CHAR + {3'b000, din_dec[4:0]};
          else                    dout_q <= BASE_CHAR + {3'b000, table_q[din_dec[4:0]]};
        end else begin
          dout_q <= din;
        end
      end
    end
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = err_q;
  assign pair_count = cnt_q;
  assign dout       = dout_q;
  assign done       = done_q;

endmodule

// File: tb/tb_plugboard.sv
// Directed self-checking bench for plugboard: data swap, pair loading/rejection,
// clear sweep, async reset mid-commit and the lowercase build option.
module tb_plugboard;

  logic       clk = 1'b0;
  logic       reset_n, clear, cfg_valid, valid;
  logic [7:0] cfg_a, cfg_b, din;
  logic       cfg_ready, cfg_err, busy, done;
  logic [3:0] pair_count;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  plugboard #(.NUM_LETTERS(26), .BASE_CHAR(8'h41), .MAX_PAIRS(13)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .pair_count(pair_count), .busy(busy),
    .valid(valid), .din(din), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] ch, input logic [7:0] exp);
    @(negedge clk);
    valid = 1'b1;
    din   = ch;
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic end_data();
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_low", 32'(done), 32'd0);
  endtask

  // Returns number of busy cycles after the accept edge (bounded).
  task automatic cfg_req(input logic [7:0] a, input logic [7:0] b, output int n);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_a     = a;
    cfg_b     = b;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_clear(output int n);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] ch, pc;
    reset_n = 1'b0; clear = 1'b0; cfg_valid = 1'b0; cfg_a = '0; cfg_b = '0;
    valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_count", 32'(pair_count), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // identity data, back-to-back
    send("id_A", 8'h41, 8'h41);
    send("id_M", 8'h4D, 8'h4D);
    send("id_5", 8'h35, 8'h35);
    end_data();
    check("dout_hold", 32'(dout), 32'h35);

    // A/Z pair
    cfg_req(8'h41, 8'h5A, n);
    check("AZ_busy", 32'(n), 32'd2);
    check("AZ_count", 32'(pair_count), 32'd1);
    check("AZ_err", 32'(cfg_err), 32'd0);
    send("AZ_A", 8'h41, 8'h5A);
    send("AZ_Z", 8'h5A, 8'h41);
    send("AZ_B", 8'h42, 8'h42);
    end_data();

    // rejections
    cfg_req(8'h41, 8'h42, n);
    check("AB_busy", 32'(n), 32'd1);
    check("AB_err", 32'(cfg_err), 32'd1);
    check("AB_count", 32'(pair_count), 32'd1);
    send("AB_B", 8'h42, 8'h42);
    end_data();
    cfg_req(8'h43, 8'h43, n);
    check("CC_err", 32'(cfg_err), 32'd1);
    cfg_req(8'h40, 8'h44, n);
    check("oor_err", 32'(cfg_err), 32'd1);
    check("oor_count", 32'(pair_count), 32'd1);
    cfg_req(8'h43, 8'h44, n);
    check("CD_err", 32'(cfg_err), 32'd0);
    check("CD_count", 32'(pair_count), 32'd2);

    // load to 5 pairs, set err, then clear with a late letter sent mid-sweep
    cfg_req(8'h45, 8'h46, n);
    cfg_req(8'h47, 8'h48, n);
    cfg_req(8'h49, 8'h4A, n);
    check("five_count", 32'(pair_count), 32'd5);
    cfg_req(8'h41, 8'h41, n);
    check("pre_clr_err", 32'(cfg_err), 32'd1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      valid = (n == 10);
      din   = 8'h5A;
      @(posedge clk);
      #1;
      if (n == 10) check("sweep_Z", 32'(dout), 32'h5A);
      n++;
    end
    valid = 1'b0;
    check("clr_busy", 32'(n), 32'd26);
    check("clr_count", 32'(pair_count), 32'd0);
    check("clr_err", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 26; i++) begin
      ch = 8'(8'h41 + i);
      send("clr_map", ch, ch);
    end
    end_data();

    // 13 disjoint pairs X <-> X+13, then a 14th request
    for (int i = 0; i < 13; i++) begin
      cfg_req(8'(8'h41 + i), 8'(8'h4E + i), n);
      check("p13_busy", 32'(n), 32'd2);
    end
    check("p13_count", 32'(pair_count), 32'd13);
    check("p13_err", 32'(cfg_err), 32'd0);
    cfg_req(8'h41, 8'h42, n);
    check("p14_err", 32'(cfg_err), 32'd1);
    check("p14_count", 32'(pair_count), 32'd13);
    for (int i = 0; i < 26; i++) begin
      ch = 8'(8'h41 + i);
      pc = 8'(8'h41 + ((i + 13) % 26));
      send("p13_map", ch, pc);
    end
    end_data();

    // clear during CHECK discards the pair
    do_clear(n);
    check("clr2_busy", 32'(n), 32'd26);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_a = 8'h42; cfg_b = 8'h43;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("chk_clr_busy", 32'(n), 32'd26);
    check("chk_clr_count", 32'(pair_count), 32'd0);
    send("chk_clr_B", 8'h42, 8'h42);
    send("chk_clr_C", 8'h43, 8'h43);
    end_data();

    // async reset while in COMMIT
    @(negedge clk);
    cfg_valid = 1'b1; cfg_a = 8'h41; cfg_b = 8'h5A;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    valid = 1'b1; din = 8'h51;
    @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_done", 32'(done), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_count", 32'(pair_count), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    reset_n = 1'b1;
    send("post_rst_A", 8'h41, 8'h41);
    send("post_rst_Z", 8'h5A, 8'h5A);
    end_data();

    // lowercase handling
    cfg_req(8'h41, 8'h5A, n);
    check("lc_AZ_count", 32'(pair_count), 32'd1);
`ifdef PLUGBOARD_LOWERCASE_EN
    send("lc_a", 8'h61, 8'h5A);
    end_data();
    cfg_req(8'h62, 8'h63, n);
    check("lc_bc_err", 32'(cfg_err), 32'd0);
    check("lc_bc_count", 32'(pair_count), 32'd2);
    send("lc_B", 8'h42, 8'h43);
    send("lc_c", 8'h63, 8'h42);
`else
    send("lc_a", 8'h61, 8'h61);
    end_data();
    cfg_req(8'h62, 8'h63, n);
    check("lc_bc_err", 32'(cfg_err), 32'd1);
    check("lc_bc_count", 32'(pair_count), 32'd1);
    send("lc_B", 8'h42, 8'h42);
    send("lc_c", 8'h63, 8'h63);
`endif
    end_data();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
